// File: rtl/risc_mem_pkg.sv
// rtl/risc_mem_pkg.sv - shared types and sizes for the memory responder
package risc_mem_pkg;

    localparam int WORD_W    = 16;
    localparam int BURST_W   = 3;
    localparam int MAX_BEATS = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_BEAT = 2'd2
    } state_e;

endpackage

// File: rtl/mem_array.sv
// rtl/mem_array.sv - single-port word RAM, synchronous write, asynchronous read
module mem_array #(
    parameter int DEPTH  = 256,
    parameter int DATA_W = 16,
    parameter int AW     = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic              clk,
    input  logic              we,
    input  logic [AW-1:0]     addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/mem_responder.sv
// rtl/mem_responder.sv - request/beat FSM with wait states and 1-8 word bursts
module mem_responder
    import risc_mem_pkg::*;
#(
    parameter int ADDR_W      = 16,
    parameter int DATA_W      = WORD_W,
    parameter int DEPTH       = 256,
    parameter int WAIT_CYCLES = 2
) (
    input  logic               clk,
    input  logic               proc_rst,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic               req_write,
    input  logic [ADDR_W-1:0]  req_addr,
    input  logic [BURST_W-1:0] req_len,
    input  logic               wr_valid,
    output logic               wr_ready,
    input  logic [DATA_W-1:0]  wr_data,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [DATA_W-1:0]  rsp_data,
    output logic               rsp_last,
    output logic               done,
    output logic               err
);

    localparam int MAW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int WC_W = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
    localparam logic [WC_W-1:0] WC_INIT = WC_W'(WAIT_CYCLES);

    state_e             state;
    logic               write_q;
    logic [ADDR_W-1:0]  addr_q;
    logic [BURST_W-1:0] len_q;
    logic [BURST_W-1:0] beat_q;
    logic [WC_W-1:0]    wait_cnt;

    logic               accept;
    logic               fire;
    logic               last_beat;
    logic               to_beat;
    logic               load_write;
    logic [ADDR_W-1:0]  addr_inc;
    logic [ADDR_W-1:0]  load_addr;
    logic [ADDR_W-1:0]  port_addr;
    logic               load_in_range;
    logic               mem_we;
    logic [DATA_W-1:0]  rd_word;

    function automatic logic in_range(input logic [ADDR_W-1:0] a);
        return 32'(a) < DEPTH;
    endfunction

    assign req_ready = (state == ST_IDLE);
    assign accept    = req_valid & req_ready;
    assign wr_ready  = (state == ST_BEAT) & write_q;
    assign rsp_valid = (state == ST_BEAT) & ~write_q;
    assign last_beat = (beat_q == len_q);
    assign rsp_last  = rsp_valid & last_beat;
    assign fire      = write_q ? (wr_ready & wr_valid) : (rsp_valid & rsp_ready);
    assign addr_inc  = addr_q + ADDR_W'(1);

    // load_addr is the word that the next BEAT will serve; its read data is captured on entry
    always_comb begin
        to_beat    = 1'b0;
        load_addr  = addr_q;
        load_write = write_q;
        case (state)
            ST_IDLE: begin
                load_addr  = req_addr;
                load_write = req_write;
                to_beat    = accept && (WAIT_CYCLES == 0);
            end
            ST_WAIT: to_beat = (wait_cnt == WC_W'(1));
            ST_BEAT: begin
                load_addr = addr_inc;
                to_beat   = fire && !last_beat && (WAIT_CYCLES == 0);
            end
            default: to_beat = 1'b0;
        endcase
    end

    assign load_in_range = in_range(load_addr);
    assign port_addr     = ((state == ST_BEAT) && write_q) ? addr_q : load_addr;
    assign mem_we        = fire & write_q & in_range(addr_q);

    mem_array #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W),
        .AW     (MAW)
    ) u_mem_array (
        .clk   (clk),
        .we    (mem_we),
        .addr  (MAW'(port_addr)),
        .wdata (wr_data),
        .rdata (rd_word)
    );

    always_ff @(posedge clk) begin
        if (proc_rst) begin
            state    <= ST_IDLE;
            write_q  <= 1'b0;
            addr_q   <= '0;
            len_q    <= '0;
            beat_q   <= '0;
            wait_cnt <= '0;
            rsp_data <= '0;
            done     <= 1'b0;
            err      <= 1'b0;
        end else begin
            done <= 1'b0;
            if (to_beat && !load_write) begin
                rsp_data <= load_in_range ? rd_word : '0;
            end
            if (accept) begin
                err <= to_beat & ~load_in_range;
            end else if (to_beat && !load_in_range) begin
                err <= 1'b1;
            end
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        write_q  <= req_write;
                        addr_q   <= req_addr;
                        len_q    <= req_len;
                        beat_q   <= '0;
                        wait_cnt <= WC_INIT;
                        state    <= to_beat ? ST_BEAT : ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    wait_cnt <= wait_cnt - WC_W'(1);
                    if (to_beat) begin
                        state <= ST_BEAT;
                    end
                end
                ST_BEAT: begin
                    if (fire) begin
                        if (last_beat) begin
                            state <= ST_IDLE;
                            done  <= 1'b1;
                        end else begin
                            addr_q   <= addr_inc;
                            beat_q   <= beat_q + BURST_W'(1);
                            wait_cnt <= WC_INIT;
                            state    <= to_beat ? ST_BEAT : ST_WAIT;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_responder.sv
// tb/tb_mem_responder.sv - scoreboard bench for mem_responder (wait-state and zero-wait/8-bit-address units)
module tb_mem_responder;

    logic        clk = 1'b0;
    logic        proc_rst;
    logic        req_valid [2];
    logic        req_ready [2];
    logic        req_write [2];
    logic [15:0] req_addr0;
    logic [7:0]  req_addr1;
    logic [2:0]  req_len   [2];
    logic        wr_valid  [2];
    logic        wr_ready  [2];
    logic [15:0] wr_data   [2];
    logic        rsp_valid [2];
    logic        rsp_ready [2];
    logic [15:0] rsp_data  [2];
    logic        rsp_last  [2];
    logic        done      [2];
    logic        err       [2];

    always #5 clk = ~clk;

    mem_responder #(.ADDR_W(16), .DATA_W(16), .DEPTH(256), .WAIT_CYCLES(2)) dut (
        .clk(clk), .proc_rst(proc_rst),
        .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_write(req_write[0]),
        .req_addr(req_addr0), .req_len(req_len[0]),
        .wr_valid(wr_valid[0]), .wr_ready(wr_ready[0]), .wr_data(wr_data[0]),
        .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]), .rsp_data(rsp_data[0]),
        .rsp_last(rsp_last[0]), .done(done[0]), .err(err[0])
    );

    mem_responder #(.ADDR_W(8), .DATA_W(16), .DEPTH(256), .WAIT_CYCLES(0)) dut_w (
        .clk(clk), .proc_rst(proc_rst),
        .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_write(req_write[1]),
        .req_addr(req_addr1), .req_len(req_len[1]),
        .wr_valid(wr_valid[1]), .wr_ready(wr_ready[1]), .wr_data(wr_data[1]),
        .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]), .rsp_data(rsp_data[1]),
        .rsp_last(rsp_last[1]), .done(done[1]), .err(err[1])
    );

    typedef struct packed {
        logic [15:0] data;
        logic        last;
    } exp_t;

    int          checks = 0;
    int          failures = 0;
    exp_t        sb [$];
    logic [15:0] model [2][256];
    int          done_cnt [2] = '{0, 0};
    int          done_exp [2] = '{0, 0};

    always @(posedge clk) begin
        if (!proc_rst && done[0]) done_cnt[0] <= done_cnt[0] + 1;
        if (!proc_rst && done[1]) done_cnt[1] <= done_cnt[1] + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic run(input int u, input bit wr, input int addr, input int len,
                       input int dbase, input int bp_beat, input int abort_after);
        int   wait_cycles;
        int   amask;
        int   a;
        int   b = 0;
        int   cyc = 0;
        int   hold = 0;
        bit   first = 1'b1;
        bit   exp_err = 1'b0;
        bit   aborted = 1'b0;
        exp_t e;
        wait_cycles = (u == 0) ? 2 : 0;
        amask       = (u == 0) ? 32'hFFFF : 32'hFF;
        for (int i = 0; i <= len; i++) begin
            a = (addr + i) & amask;
            if (a >= 256) exp_err = 1'b1;
            if (!wr) begin
                e.data = (a >= 256) ? 16'h0 : model[u][a];
                e.last = (i == len);
                sb.push_back(e);
            end
        end
        @(negedge clk);
        check("req_ready_idle", req_ready[u], 1);
        req_valid[u] = 1'b1;
        req_write[u] = wr;
        if (u == 0) req_addr0 = addr[15:0];
        else        req_addr1 = addr[7:0];
        req_len[u]   = len[2:0];
        rsp_ready[u] = 1'b1;
        wr_valid[u]  = 1'b0;
        @(posedge clk);
        #1 req_valid[u] = 1'b0;
        while (b <= len && cyc < 300 && !aborted) begin
            @(negedge clk);
            cyc++;
            if (wr) begin
                wr_valid[u] = 1'b0;
                if (wr_ready[u]) begin
                    if (first) begin
                        check("wr_latency", cyc, wait_cycles + 1);
                        first = 1'b0;
                    end
                    if (b == abort_after) begin
                        proc_rst = 1'b1;
                        aborted  = 1'b1;
                    end else begin
                        a = (addr + b) & amask;
                        wr_valid[u] = 1'b1;
                        wr_data[u]  = 16'(dbase + b);
                        if (a < 256) model[u][a] = wr_data[u];
                        b++;
                    end
                end
            end else if (rsp_valid[u] && sb.size() > 0) begin
                if (first) begin
                    check("rd_latency", cyc, wait_cycles + 1);
                    first = 1'b0;
                end
                e = sb[0];
                if (b == bp_beat && hold < 4) begin
                    rsp_ready[u] = 1'b0;
                    check("bp_valid", rsp_valid[u], 1);
                    check("bp_data", rsp_data[u], e.data);
                    hold++;
                end else begin
                    rsp_ready[u] = 1'b1;
                    e = sb.pop_front();
                    check("rd_data", rsp_data[u], e.data);
                    check("rd_last", rsp_last[u], e.last);
                    b++;
                end
            end
        end
        if (aborted) begin
            @(negedge clk);
            check("abort_req_ready", req_ready[u], 1);
            check("abort_wr_ready", wr_ready[u], 0);
            check("abort_done", done[u], 0);
            check("abort_err", err[u], 0);
            proc_rst = 1'b0;
        end else begin
            check("beats_done", b, len + 1);
            @(negedge clk);
            wr_valid[u] = 1'b0;
            check("done_pulse", done[u], 1);
            check("req_ready_after", req_ready[u], 1);
            check("err", err[u], exp_err);
            done_exp[u]++;
            @(negedge clk);
            check("done_once", done[u], 0);
        end
    endtask

    initial begin
        proc_rst = 1'b1;
        req_addr0 = '0;
        req_addr1 = '0;
        for (int u = 0; u < 2; u++) begin
            req_valid[u] = 1'b0;
            req_write[u] = 1'b0;
            req_len[u]   = '0;
            wr_valid[u]  = 1'b0;
            wr_data[u]   = '0;
            rsp_ready[u] = 1'b0;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int u = 0; u < 2; u++) begin
            check("rst_req_ready", req_ready[u], 1);
            check("rst_wr_ready", wr_ready[u], 0);
            check("rst_rsp_valid", rsp_valid[u], 0);
            check("rst_rsp_data", rsp_data[u], 0);
            check("rst_rsp_last", rsp_last[u], 0);
            check("rst_done", done[u], 0);
            check("rst_err", err[u], 0);
        end
        proc_rst = 1'b0;

        // single word, then full bursts with backpressure on beat 2
        run(0, 1, 5, 0, 16'hBEEF, -1, -1);
        run(0, 0, 5, 0, 0, -1, -1);
        run(0, 1, 16'h10, 7, 16'h1000, -1, -1);
        run(0, 0, 16'h10, 7, 0, 2, -1);

        // out of range: 0x100 must not alias onto word 0
        run(0, 1, 0, 0, 16'h1234, -1, -1);
        run(0, 1, 16'h100, 0, 16'hDEAD, -1, -1);
        run(0, 0, 16'h100, 0, 0, -1, -1);
        run(0, 0, 0, 0, 0, -1, -1);

        // reset after three of eight store beats
        run(0, 1, 16'h20, 7, 16'hA000, -1, -1);
        run(0, 1, 16'h20, 7, 16'hB000, -1, 3);
        run(0, 0, 16'h20, 7, 0, -1, -1);

        // 8-bit address wrap with zero wait states
        run(1, 1, 2, 0, 16'h5555, -1, -1);
        run(1, 1, 16'hFE, 3, 16'h7000, -1, -1);
        run(1, 0, 16'hFE, 3, 0, 1, -1);
        run(1, 0, 2, 0, 0, -1, -1);

        repeat (2) @(negedge clk);
        check("done_count_u0", done_cnt[0], done_exp[0]);
        check("done_count_u1", done_cnt[1], done_exp[1]);
        check("sb_empty", sb.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
